// File: rtl/serial_addsub_if.sv
// Start/done handshake and result bus between the control unit and the
// bit-serial add/sub unit.
interface serial_addsub_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell reused over WIDTH
// clocks, LSB first. Subtraction is computed as a + ~b + 1.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt, res_q;
    logic [CW-1:0]    cnt;
    logic             carry, carry_nxt, bit_s, last_bit, sub_q;
    logic             cout_q, ovf_q, zero_q;
    logic             busy_c, done_c;

    // Single full-adder cell working on the current LSBs.
    always_comb begin
        bit_s     = op_a[0] ^ op_b[0] ^ carry;
        carry_nxt = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        acc_nxt   = {bit_s, acc[WIDTH-1:1]};
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                busy_c = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a  <= bus.a;
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub;
                        sub_q <= bus.sub;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= {1'b0, op_a[WIDTH-1:1]};
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    acc   <= acc_nxt;
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    // On the MSB, 'carry' is the carry into the MSB; publish results.
                    if (last_bit) begin
                        res_q  <= acc_nxt;
                        cout_q <= carry_nxt ^ sub_q;
                        ovf_q  <= carry_nxt ^ carry;
                        zero_q <= (acc_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.result   = res_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: hand-computed vectors, handshake timing,
// ignored starts and mid-operation reset.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    serial_addsub_if #(.WIDTH(8)) bus();

    serial_addsub #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Present an operation for one cycle; returns after the accepting edge.
    task automatic launch(input logic s, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Sample 12 cycles after acceptance; done_at is the cycle index of done.
    task automatic wait_done(output int done_at, output int nbusy, output int ndone);
        done_at = -1;
        nbusy   = 0;
        ndone   = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic op_check(input string tag, input logic s, input logic [7:0] av,
                            input logic [7:0] bv, input logic [7:0] r, input logic c,
                            input logic v, input logic z);
        int at, nb, nd;
        launch(s, av, bv);
        wait_done(at, nb, nd);
        chk({tag, " done_at"}, at, 8);
        chk({tag, " ndone"}, nd, 1);
        chk({tag, " result"}, bus.result, r);
        chk({tag, " cout"}, bus.cout, c);
        chk({tag, " ovf"}, bus.overflow, v);
        chk({tag, " zero"}, bus.zero, z);
    endtask

    initial begin
        int at, nb, nd;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst result", bus.result, 0);
        chk("rst flags", {bus.cout, bus.overflow, bus.zero}, 0);
        rst = 1'b0;

        launch(1'b0, 8'd100, 8'd27);
        wait_done(at, nb, nd);
        chk("add1 done_at", at, 8);
        chk("add1 ndone", nd, 1);
        chk("add1 nbusy", nb, 8);
        chk("add1 result", bus.result, 127);
        chk("add1 flags", {bus.cout, bus.overflow, bus.zero}, 3'b000);

        op_check("add300", 1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0);
        op_check("add7f",  1'b0, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b1, 1'b0);
        op_check("sub5_7", 1'b1, 8'd5,   8'd7,   8'hFE,  1'b1, 1'b0, 1'b0);
        op_check("sub9_9", 1'b1, 8'd9,   8'd9,   8'h00,  1'b0, 1'b0, 1'b1);
        op_check("sub80",  1'b1, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b1, 1'b0);

        // Start during RUN is ignored; result holds previous value mid-run.
        launch(1'b0, 8'd1, 8'd2);
        nd = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.sub = 1'b1; bus.a = 8'd50; bus.b = 8'd10;
            end
            if (i == 3) bus.start = 1'b0;
            if (i == 4) chk("hold midrun", bus.result, 8'h7F);
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("ign ndone", nd, 1);
        chk("ign result", bus.result, 3);
        chk("ign busy", bus.busy, 0);

        // Reset in the middle of an operation.
        launch(1'b0, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst busy", bus.busy, 0);
        chk("mrst result", bus.result, 0);
        chk("mrst flags", {bus.done, bus.cout, bus.overflow, bus.zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) nd++;
            @(negedge clk);
        end
        chk("mrst no done", nd, 0);
        op_check("addff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0);

        // Start during DONE is ignored; held into IDLE it is accepted.
        launch(1'b0, 8'd3, 8'd4);
        at = -1;
        for (int i = 0; i < 12 && at < 0; i++) begin
            if (bus.done) at = i;
            else @(negedge clk);
        end
        chk("d2 first done", at, 8);
        bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'd10; bus.b = 8'd20;
        @(negedge clk);
        chk("d2 idle busy", bus.busy, 0);
        chk("d2 idle result", bus.result, 7);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(at, nb, nd);
        chk("d2 done_at", at, 8);
        chk("d2 ndone", nd, 1);
        chk("d2 result", bus.result, 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
